// File: rtl/latch_event_pkg.sv
// Shared types, constants and helpers for the latch event reader.
package latch_event_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        FLUSH
    } state_e;

    localparam int unsigned SYNC_STAGES  = 2;
    localparam int unsigned FLUSH_CYCLES = 3;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic int unsigned lowest_set_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchroniser with synchronous active-high reset.
module sync_2ff
    import latch_event_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] stage_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/latch_event_reader.sv
// Scans synchronised latch outputs and reports each set line once as a valid/ready event.
// Optional saturating accept counter on evt_count when LATCH_EVT_COUNT_EN is defined.
module latch_event_reader
    import latch_event_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned IDX_W    = 2,
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     latch_q,
    output logic [N-1:0]     latch_clr,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    input  logic             evt_ready,
`ifdef LATCH_EVT_COUNT_EN
    output logic [15:0]      evt_count,
`endif
    output logic             busy
);

    localparam int unsigned CNT_W   = $clog2(SCAN_DIV);
    localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES);

    logic [N-1:0]       sync_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               tick;
    state_e             state_q;
    logic [N-1:0]       pending_q;
    logic [FLUSH_W-1:0] flush_cnt_q;
    logic               evt_valid_q;
    logic [IDX_W-1:0]   evt_idx_q;
    logic [N-1:0]       latch_clr_q;
    logic               busy_q;
    logic               accept;
    logic [N-1:0]       clr_vec;

    for (genvar i = 0; i < N; i++) begin : g_sync
        sync_2ff u_sync (
            .clk_i   (clk),
            .reset_i (reset),
            .d_i     (latch_q[i]),
            .q_o     (sync_q[i])
        );
    end

    // Free-running in every state; ticks outside IDLE are simply ignored.
    always_ff @(posedge clk) begin
        if (reset || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = (cnt_q == CNT_W'(SCAN_DIV - 1));

    always_comb begin
        accept  = evt_valid_q && evt_ready;
        clr_vec = '0;
        for (int i = 0; i < N; i++) begin
            clr_vec[i] = (evt_idx_q == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            flush_cnt_q <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            latch_clr_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            latch_clr_q <= '0;
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        pending_q <= sync_q;
                        if (|sync_q) begin
                            state_q     <= PRESENT;
                            evt_valid_q <= 1'b1;
                            evt_idx_q   <= IDX_W'(lowest_set_idx(32'(sync_q)));
                            busy_q      <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        latch_clr_q <= clr_vec;
                        pending_q   <= pending_q & ~clr_vec;
                        evt_valid_q <= 1'b0;
                        flush_cnt_q <= '0;
                        state_q     <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Give the clear time to reach the latch and ripple through the synchroniser.
                    if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                        if (|pending_q) begin
                            state_q     <= PRESENT;
                            evt_valid_q <= 1'b1;
                            evt_idx_q   <= IDX_W'(lowest_set_idx(32'(pending_q)));
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_idx   = evt_idx_q;
    assign latch_clr = latch_clr_q;
    assign busy      = busy_q;

`ifdef LATCH_EVT_COUNT_EN
    logic [15:0] evt_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_count_q <= '0;
        end else if (accept && (evt_count_q != 16'hFFFF)) begin
            evt_count_q <= evt_count_q + 16'd1;
        end
    end

    assign evt_count = evt_count_q;
`endif

endmodule
